// File: rtl/draw_arb_pkg.sv
// -----------------------------------------------------------------------------
// draw_arb_pkg
//   Shared definitions for the draw arbiter: FSM state encoding, default
//   sizing of the random value path, and requester index assignments.
//   Optional feature macro used by the arbiter: DRAW_ARB_RR_EN.
// -----------------------------------------------------------------------------
package draw_arb_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    SAMPLE  = 3'd2,
    GRANT   = 3'd3,
    RELEASE = 3'd4
  } arb_state_e;

  localparam int NUM_REQ_DEF   = 3;
  localparam int VAL_W_DEF     = 5;
  localparam int MAX_VAL_DEF   = 13;
  localparam int RETRY_MAX_DEF = 3;

  // Requester slots on the req/ack buses
  localparam int REQ_PLAYER = 0;
  localparam int REQ_DEALER = 1;
  localparam int REQ_SPIN   = 2;

  // total_draws is a 5-bit saturating counter
  localparam int         TOTAL_W   = 5;
  localparam logic [4:0] TOTAL_MAX = 5'd31;

endpackage

// File: rtl/draw_arb_pick.sv
// -----------------------------------------------------------------------------
// draw_arb_pick
//   Combinational rotating-priority picker. Starting at index 'start' and
//   wrapping past NUM_REQ-1 back to 0, the first set req bit wins.
//   Ports:
//     req    in   NUM_REQ  request vector
//     start  in   PTR_W    index searched first (tie to 0 for fixed priority)
//     grant  out  NUM_REQ  one-hot winner (all zero when no request)
//     any    out  1        at least one request present
// -----------------------------------------------------------------------------
module draw_arb_pick
  import draw_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   start,
  output logic [NUM_REQ-1:0] grant,
  output logic               any
);

  logic found_s;

  assign any = |req;

  // First requester found in search order (start, start+1, ...) wins
  always_comb begin
    grant   = '0;
    found_s = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        grant[j] = grant[j] |
                   (!found_s && req[j] && (j == ((int'(start) + i) % NUM_REQ)));
      end
      found_s = |grant;
    end
  end

endmodule

// File: rtl/draw_arbiter.sv
// -----------------------------------------------------------------------------
// draw_arbiter
//   Shares one free-running random-number source among the player draw,
//   dealer draw and roulette spin requesters. One request is served at a
//   time: the source is advanced with rng_load, the sample is range-checked
//   (1..MAX_VAL), resampled up to RETRY_MAX times, then folded into range
//   if still illegal, and returned with a one-cycle one-hot ack.
//   Configuration macro: DRAW_ARB_RR_EN (defined = round-robin arbitration,
//   undefined = fixed priority with req[0] highest).
//   Ports:
//     CLOCK_50     in   1        system clock, rising edge
//     reset        in   1        synchronous reset, active-high
//     req          in   NUM_REQ  level requests, held until ack
//     rng_q        in   VAL_W    current random source output
//     rng_load     out  1        one-cycle pulse advancing the source
//     ack          out  NUM_REQ  one-hot one-cycle completion pulse
//     draw_val     out  VAL_W    drawn value, held between grants
//     busy         out  1        high whenever the FSM is not IDLE
//     round_clr    in   1        clears total_draws
//     total_draws  out  5        saturating count of successful draws
// -----------------------------------------------------------------------------
module draw_arbiter
  import draw_arb_pkg::*;
#(
  parameter int NUM_REQ   = NUM_REQ_DEF,
  parameter int VAL_W     = VAL_W_DEF,
  parameter int MAX_VAL   = MAX_VAL_DEF,
  parameter int RETRY_MAX = RETRY_MAX_DEF
) (
  input  logic                 CLOCK_50,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [VAL_W-1:0]     rng_q,
  output logic                 rng_load,
  output logic [NUM_REQ-1:0]   ack,
  output logic [VAL_W-1:0]     draw_val,
  output logic                 busy,
  input  logic                 round_clr,
  output logic [TOTAL_W-1:0]   total_draws
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int RT_W  = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;
  localparam logic [VAL_W-1:0] MAX_V  = VAL_W'(MAX_VAL);
  localparam logic [RT_W-1:0]  RT_MAX = RT_W'(RETRY_MAX);

  arb_state_e           state_r, state_s;
  logic [NUM_REQ-1:0]   winner_r;
  logic [RT_W-1:0]      retries_r;
  logic [NUM_REQ-1:0]   pick_grant_s;
  logic                 pick_any_s;
  logic [PTR_W-1:0]     ptr_s;
  logic                 win_live_s;
  logic                 in_range_s;

  // Out-of-range samples are folded into 1..MAX_VAL once retries run out
  function automatic logic [VAL_W-1:0] fold_val(input logic [VAL_W-1:0] v);
    return (v % MAX_V) + VAL_W'(1);
  endfunction

`ifdef DRAW_ARB_RR_EN
  logic [PTR_W-1:0] ptr_r;

  // Index following the one-hot winner, wrapping NUM_REQ-1 -> 0
  function automatic logic [PTR_W-1:0] next_ptr(input logic [NUM_REQ-1:0] oh);
    logic [PTR_W-1:0] r;
    r = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      r = oh[j] ? ((j == NUM_REQ - 1) ? PTR_W'(0) : PTR_W'(j + 1)) : r;
    end
    return r;
  endfunction

  // Round-robin pointer moves past each completed grant
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      ptr_r <= '0;
    end else if (state_r == GRANT) begin
      ptr_r <= next_ptr(winner_r);
    end
  end

  assign ptr_s = ptr_r;
`else
  assign ptr_s = '0;
`endif

  draw_arb_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_pick (
    .req   (req),
    .start (ptr_s),
    .grant (pick_grant_s),
    .any   (pick_any_s)
  );

  // The served requester is still asking; dropping it aborts or releases
  assign win_live_s = |(req & winner_r);
  assign in_range_s = (rng_q != '0) && (rng_q <= MAX_V);

  // State register
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; abort has priority over sample evaluation
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (pick_any_s) state_s = LOAD;
        else            state_s = IDLE;
      end
      LOAD: begin
        if (win_live_s) state_s = SAMPLE;
        else            state_s = IDLE;
      end
      SAMPLE: begin
        if (!win_live_s)            state_s = IDLE;
        else if (in_range_s)        state_s = GRANT;
        else if (retries_r < RT_MAX) state_s = LOAD;
        else                        state_s = GRANT;
      end
      GRANT: begin
        state_s = RELEASE;
      end
      RELEASE: begin
        if (win_live_s) state_s = RELEASE;
        else            state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Registered outputs decoded from the state being entered, plus datapath
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      rng_load    <= 1'b0;
      ack         <= '0;
      busy        <= 1'b0;
      draw_val    <= '0;
      total_draws <= '0;
      winner_r    <= '0;
      retries_r   <= '0;
    end else begin
      rng_load <= (state_s == LOAD);
      ack      <= (state_s == GRANT) ? winner_r : '0;
      busy     <= (state_s != IDLE);

      if (state_r == IDLE) begin
        winner_r <= pick_grant_s;
      end

      if (state_r == SAMPLE && state_s == LOAD) begin
        retries_r <= retries_r + RT_W'(1);
      end else if (state_s == IDLE || state_r == GRANT) begin
        retries_r <= '0;
      end

      if (state_r == SAMPLE && state_s == GRANT) begin
        draw_val <= in_range_s ? rng_q : fold_val(rng_q);
      end

      // A clear coinciding with GRANT still counts that grant
      if (round_clr) begin
        total_draws <= (state_r == GRANT) ? TOTAL_W'(1) : TOTAL_W'(0);
      end else if (state_r == GRANT && total_draws != TOTAL_MAX) begin
        total_draws <= total_draws + TOTAL_W'(1);
      end
    end
  end

endmodule
